// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between I-cache and D-cache.
// Ports: clk, rst_n (async, active-low);
//   i_req/i_we/i_addr/i_wdata in, i_rdata/i_ready out : I-port requester
//   d_req/d_we/d_addr/d_wdata in, d_rdata/d_ready out : D-port requester
//   mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in : memory
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128,
   parameter bit RR     = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
   logic                i_ready_q, i_ready_d;
   logic                d_ready_q, d_ready_d;

   logic                grant;
   logic                gnt_port;
   logic                pick_d;
   logic                other_req;

   // Tie in IDLE: D wins unless round-robin says I is due
   // (last grant went to D).
   assign pick_d = d_req
                 & (~i_req | ~RR | (last_q == PORT_I));

   // In DONE only the non-owner may be handed the port;
   // the owner's req is still high but is being dropped.
   assign other_req = (owner_q == PORT_D) ? i_req : d_req;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      grant       = 1'b0;
      gnt_port    = PORT_I;

      unique case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               grant    = 1'b1;
               gnt_port = pick_d ? PORT_D : PORT_I;
            end
         end
         S_BUSY: begin
            if (mem_ready) begin
               mem_req_d = 1'b0;
               state_d   = S_DONE;
               if (owner_q == PORT_D) begin
                  d_rdata_d = mem_rdata;
                  d_ready_d = 1'b1;
               end else begin
                  i_rdata_d = mem_rdata;
                  i_ready_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (other_req) begin
               grant    = 1'b1;
               gnt_port = ~owner_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (grant) begin
         state_d   = S_BUSY;
         mem_req_d = 1'b1;
         owner_d   = gnt_port;
         last_d    = gnt_port;
         if (gnt_port == PORT_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
         end else begin
            mem_we_d    = i_we;
            mem_addr_d  = i_addr;
            mem_wdata_d = i_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         owner_q     <= PORT_I;
         last_q      <= PORT_I;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign i_ready   = i_ready_q;
   assign d_rdata   = d_rdata_q;
   assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and a randomized
// transaction-level model for mem_arbiter (RR=1 and RR=0 instances).
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          i_req, i_we, i_ready;
   logic [AW-1:0] i_addr;
   logic [LW-1:0] i_wdata, i_rdata;
   logic          d_req, d_we, d_ready;
   logic [AW-1:0] d_addr;
   logic [LW-1:0] d_wdata, d_rdata;
   logic          mem_req, mem_we, mem_ready;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata, mem_rdata;

   logic          f_i_req, f_i_we, f_i_ready;
   logic [AW-1:0] f_i_addr;
   logic [LW-1:0] f_i_wdata, f_i_rdata;
   logic          f_d_req, f_d_we, f_d_ready;
   logic [AW-1:0] f_d_addr;
   logic [LW-1:0] f_d_wdata, f_d_rdata;
   logic          f_mem_req, f_mem_we, f_mem_ready;
   logic [AW-1:0] f_mem_addr;
   logic [LW-1:0] f_mem_wdata, f_mem_rdata;

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
      .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready)
   );

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .i_req(f_i_req), .i_we(f_i_we), .i_addr(f_i_addr),
      .i_wdata(f_i_wdata), .i_rdata(f_i_rdata), .i_ready(f_i_ready),
      .d_req(f_d_req), .d_we(f_d_we), .d_addr(f_d_addr),
      .d_wdata(f_d_wdata), .d_rdata(f_d_rdata), .d_ready(f_d_ready),
      .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
      .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata),
      .mem_ready(f_mem_ready)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] line_of(input logic [31:0] a);
      return {32'hDEADBEEF, a, ~a, 32'hDEADBEEF ^ a};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Memory models: mem_ready in the cycle that is lat cycles after
   // mem_req rises; inj forces one stray mem_ready pulse.
   int lat0 = 3;
   bit inj0 = 0;
   initial begin : mem_rr
      int cnt;
      cnt = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_ready) begin
            mem_ready = 1'b0;
            cnt = 0;
         end else if (inj0) begin
            mem_ready = 1'b1;
            mem_rdata = line_of(mem_addr);
            inj0 = 0;
         end else if (mem_req) begin
            cnt++;
            if (cnt == lat0 + 1) begin
               mem_ready = 1'b1;
               mem_rdata = line_of(mem_addr);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   int latf = 1;
   initial begin : mem_fp
      int cnt;
      cnt = 0;
      f_mem_ready = 1'b0;
      f_mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (f_mem_ready) begin
            f_mem_ready = 1'b0;
            cnt = 0;
         end else if (f_mem_req) begin
            cnt++;
            if (cnt == latf + 1) begin
               f_mem_ready = 1'b1;
               f_mem_rdata = line_of(f_mem_addr);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   typedef struct {
      logic         port;
      logic         we;
      logic [31:0]  addr;
      logic [127:0] wdata;
      int           lat;
      logic [127:0] rdata;
   } vec_t;

   task automatic do_reset;
      rst_n = 1'b0;
      i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      repeat (2) tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int n;
      bit got, stable, other;
      lat0 = v.lat;
      if (v.port) begin
         d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         i_req = 1; i_we = v.we; i_addr = v.addr; i_wdata = v.wdata;
      end
      tick;
      chk({nm, " mem_req"}, mem_req, 1'b1);
      chk({nm, " mem_addr"}, mem_addr, v.addr);
      chk({nm, " mem_we"}, mem_we, v.we);
      chk({nm, " mem_wdata"}, mem_wdata, v.wdata);
      n = 1; got = 0; stable = 1; other = 0;
      while (!got && n < 40) begin
         tick;
         n++;
         if (mem_req && (mem_addr !== v.addr || mem_we !== v.we
             || mem_wdata !== v.wdata))
            stable = 0;
         if (v.port ? i_ready : d_ready) other = 1;
         if (v.port ? d_ready : i_ready) got = 1;
      end
      chk({nm, " ready seen"}, got, 1'b1);
      chk({nm, " latency"}, n, v.lat + 2);
      chk({nm, " rdata"}, v.port ? d_rdata : i_rdata, v.rdata);
      chk({nm, " cmd stable"}, stable, 1'b1);
      chk({nm, " other ready"}, other, 1'b0);
      if (v.port) d_req = 0; else i_req = 0;
      tick;
      chk({nm, " ready pulse"}, v.port ? d_ready : i_ready, 1'b0);
      chk({nm, " rdata held"}, v.port ? d_rdata : i_rdata, v.rdata);
      chk({nm, " idle mem_req"}, mem_req, 1'b0);
      tick;
   endtask

   task automatic drain(input string nm);
      int j;
      j = 0;
      while ((i_req || d_req || mem_req) && j < 100) begin
         if (i_ready) i_req = 0;
         if (d_ready) d_req = 0;
         tick;
         j++;
      end
      chk({nm, " drained"}, {i_req, d_req, mem_req}, 3'b000);
   endtask

   vec_t tbl[5];

   initial begin : main
      vec_t v;
      int k, n, ni, nd;
      bit after_rdy, first, dsamp, pfr;
      bit pend[2], cwe[2];
      logic [31:0] cad[2];
      logic [127:0] cwd[2];
      bit last_m, infl, pmr, rdy_prev, rdy_port, g;

      tbl[0] = '{1'b0, 1'b0, 32'h0000_1230, '0, 3,
                 128'hDEADBEEF_00001230_FFFFEDCF_DEADACDF};
      tbl[1] = '{1'b1, 1'b1, 32'h0000_0040, {32{4'h1}}, 2,
                 128'hDEADBEEF_00000040_FFFFFFBF_DEADBEAF};
      tbl[2] = '{1'b1, 1'b0, 32'hFFFF_FFF0, '0, 1,
                 128'hDEADBEEF_FFFFFFF0_0000000F_2152411F};
      tbl[3] = '{1'b0, 1'b1, 32'h0000_0000, {128{1'b1}}, 4,
                 128'hDEADBEEF_00000000_FFFFFFFF_DEADBEEF};
      tbl[4] = '{1'b0, 1'b0, 32'h1234_5678, '0, 2,
                 128'hDEADBEEF_12345678_EDCBA987_CC99E897};

      i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      f_i_req = 0; f_i_we = 0; f_i_addr = '0; f_i_wdata = '0;
      f_d_req = 0; f_d_we = 0; f_d_addr = '0; f_d_wdata = '0;
      #1;
      chk("rst mem_req", mem_req, 1'b0);
      chk("rst mem_we", mem_we, 1'b0);
      chk("rst mem_addr", mem_addr, '0);
      chk("rst mem_wdata", mem_wdata, '0);
      chk("rst i_ready", i_ready, 1'b0);
      chk("rst d_ready", d_ready, 1'b0);
      chk("rst i_rdata", i_rdata, '0);
      chk("rst d_rdata", d_rdata, '0);
      do_reset();

      for (int t = 0; t < 5; t++)
         run_vec(tbl[t], $sformatf("vec%0d", t));

      // Stray mem_ready while idle must be ignored.
      inj0 = 1;
      repeat (3) begin
         tick;
         chk("stray no effect", {i_ready, d_ready, mem_req}, 3'b000);
      end
      run_vec(tbl[4], "after stray");

      // Reset two cycles into BUSY abandons the transaction.
      lat0 = 6;
      i_req = 1; i_we = 0; i_addr = 32'h80; i_wdata = '0;
      tick;
      chk("pre-rst busy", mem_req, 1'b1);
      tick;
      tick;
      rst_n = 1'b0;
      #1;
      chk("mid-rst mem_req", mem_req, 1'b0);
      chk("mid-rst readies", {i_ready, d_ready}, 2'b00);
      chk("mid-rst mem_addr", mem_addr, '0);
      i_req = 0;
      tick;
      rst_n = 1'b1;
      tick;
      chk("post-rst idle", mem_req, 1'b0);
      v = tbl[0];
      v.lat = 2;
      run_vec(v, "post-rst");

      // RR: simultaneous requests from reset go D, I, D, I, no gap.
      do_reset();
      lat0 = 2;
      i_req = 1; i_we = 0; i_addr = 32'h1000; i_wdata = '0;
      d_req = 1; d_we = 0; d_addr = 32'h2000; d_wdata = '0;
      tick;
      chk("rr first grant D", mem_addr, 32'h2000);
      k = 0; n = 0; after_rdy = 0;
      while (k < 4 && n < 80) begin
         tick;
         n++;
         if (after_rdy) begin
            chk("rr handoff no gap", mem_req, 1'b1);
            after_rdy = 0;
         end
         if (i_ready || d_ready) begin
            chk($sformatf("rr order %0d", k), d_ready, (k % 2) == 0);
            k++;
            after_rdy = 1;
         end
      end
      chk("rr 4 grants", k, 4);
      drain("rr");

      // Fixed priority: D wins ties; I only when d_req is low.
      latf = 1;
      f_d_req = 1; f_d_addr = 32'h200;
      n = 0;
      while (!f_d_ready && n < 20) begin
         tick;
         n++;
      end
      chk("fp prime done", f_d_ready, 1'b1);
      f_d_req = 0;
      tick;
      tick;
      latf = 2;
      f_i_req = 1; f_i_addr = 32'h100;
      f_d_req = 1; f_d_addr = 32'h200;
      first = 1; ni = 0; nd = 0; pfr = 0;
      for (int c = 0; c < 80; c++) begin
         tick;
         dsamp = f_d_req;
         if (f_mem_req && !pfr) begin
            if (first) chk("fp tie to D", f_mem_addr, 32'h200);
            first = 0;
            if (f_mem_addr == 32'h200) nd++;
            else begin
               ni++;
               chk("fp I grant d_req", dsamp, 1'b0);
            end
         end
         pfr = f_mem_req;
         f_d_req = f_d_ready ? 1'b0 : 1'b1;
      end
      chk("fp I served", ni >= 2, 1'b1);
      chk("fp D served", nd >= ni, 1'b1);
      f_i_req = 0; f_d_req = 0;

      // Randomized run against a transaction-level model.
      do_reset();
      pend[0] = 0; pend[1] = 0;
      last_m = 1'b0; infl = 1'b0; pmr = 0;
      rdy_prev = 0; rdy_port = 0;
      for (int c = 0; c < 3000; c++) begin
         tick;
         if (mem_req && !pmr) begin
            chk("rnd grant has req", pend[0] || pend[1], 1'b1);
            g = (pend[0] && pend[1]) ? ~last_m : pend[1];
            if (rdy_prev) chk("rnd same port via idle", g == rdy_port, 1'b0);
            chk("rnd grant we", mem_we, cwe[g]);
            chk("rnd grant addr", mem_addr, cad[g]);
            chk("rnd grant wdata", mem_wdata, cwd[g]);
            infl = g;
            last_m = g;
            lat0 = $urandom_range(1, 4);
         end else if (mem_req) begin
            chk("rnd hold", {mem_we, mem_addr, mem_wdata},
                {cwe[infl], cad[infl], cwd[infl]});
         end
         rdy_prev = 0;
         if (i_ready || d_ready) begin
            chk("rnd ready port", {d_ready, i_ready},
                infl ? 2'b10 : 2'b01);
            chk("rnd rdata", infl ? d_rdata : i_rdata,
                line_of(cad[infl]));
            chk("rnd gap", mem_req, 1'b0);
            pend[infl] = 0;
            rdy_prev = 1;
            rdy_port = infl;
         end
         pmr = mem_req;
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 2) == 0) begin
               pend[p] = 1;
               cwe[p] = 1'($urandom);
               cad[p] = $urandom;
               cwd[p] = {$urandom, $urandom, $urandom, $urandom};
            end
         end
         i_req = pend[0]; i_we = cwe[0];
         i_addr = cad[0]; i_wdata = cwd[0];
         d_req = pend[1]; d_we = cwe[1];
         d_addr = cad[1]; d_wdata = cwd[1];
      end
      drain("rnd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule
